// File: rtl/deserializator_if.sv
// Serial receive bus for the deserializator: serial bit stream in, parallel words out.
interface deserializator_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;

  // Upstream side: drives the serial stream and consumes the rebuilt words.
  modport master (
    output ser_data_i,
    output ser_data_val_i,
    input  deser_data_o,
    input  deser_mod_o,
    input  deser_data_val_o,
    input  busy_o
  );

  // Deserializator side.
  modport slave (
    input  ser_data_i,
    input  ser_data_val_i,
    output deser_data_o,
    output deser_mod_o,
    output deser_data_val_o,
    output busy_o
  );
endinterface

// File: rtl/deserializator.sv
// Deserializator: rebuilds MSB-first serial frames into MSB-aligned parallel words.
// Frame length comes from the length of the valid burst; a burst of DATA_W bits
// closes itself, a shorter one closes on the first valid-low cycle. Bursts shorter
// than MIN_LEN are dropped without a pulse.
//
// state | meaning
// IDLE  | no frame in progress, waiting for the first valid bit
// RECV  | frame partially received, cnt holds the number of bits so far
module deserializator #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic            clk_i,
  input  logic            srst_i,
  deserializator_if.slave bus
);

  // One extra counter bit so DATA_W itself is representable for the alignment shift.
  localparam int CNT_W = MOD_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  if (DATA_W < 4 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
    $error("deserializator: DATA_W must be a power of two and at least 4");
  end

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [DATA_W-1:0] aligned;

  // Bits accumulate at the LSB end; shreg_next is only ever used when the valid
  // strobe is high, so an undefined serial bit outside a burst never gets stored.
  assign shreg_next = {shreg[DATA_W-2:0], bus.ser_data_i};

  // A short frame of cnt bits sits in the low cnt bits; move it to the MSB end
  // so the unused low bits come out as zero.
  assign aligned = shreg << (FULL_CNT - cnt);

  // Frame FSM with registered outputs.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state                <= IDLE;
      cnt                  <= '0;
      shreg                <= '0;
      bus.deser_data_o     <= '0;
      bus.deser_mod_o      <= '0;
      bus.deser_data_val_o <= 1'b0;
      bus.busy_o           <= 1'b0;
    end else begin
      bus.deser_data_val_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ser_data_val_i) begin
            shreg      <= {{(DATA_W-1){1'b0}}, bus.ser_data_i};
            cnt        <= ONE_CNT;
            bus.busy_o <= 1'b1;
            state      <= RECV;
          end
        end
        RECV: begin
          if (bus.ser_data_val_i) begin
            if (cnt == LAST_CNT) begin
              // Full word: publish directly from the shift path so the next
              // cycle is free to start another frame.
              bus.deser_data_o     <= shreg_next;
              bus.deser_mod_o      <= '0;
              bus.deser_data_val_o <= 1'b1;
              shreg                <= '0;
              cnt                  <= '0;
              bus.busy_o           <= 1'b0;
              state                <= IDLE;
            end else begin
              shreg <= shreg_next;
              cnt   <= cnt + ONE_CNT;
            end
          end else begin
            // Burst ended early: publish if long enough, otherwise keep the
            // previously published word untouched.
            if (cnt >= MIN_CNT) begin
              bus.deser_data_o     <= aligned;
              bus.deser_mod_o      <= cnt[MOD_W-1:0];
              bus.deser_data_val_o <= 1'b1;
            end
            shreg      <= '0;
            cnt        <= '0;
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          shreg      <= '0;
          cnt        <= '0;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializator.sv
// Self-checking bench for deserializator: directed frames with literal
// expectations plus randomized serializator-style traffic, checked every cycle
// against a bit-queue model and a scoreboard of sent words.
module tb_deserializator;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic clk_i  = 1'b0;
  logic srst_i = 1'b1;

  deserializator_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

  deserializator #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(3)) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (bus.slave)
  );

  // Clock generation.
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               mq[$];
  logic [15:0]      m_data = '0;
  logic [3:0]       m_mod  = '0;
  logic             m_val  = 1'b0;
  logic             m_busy = 1'b0;

  function automatic logic [15:0] pack_bits(input bit q[$]);
    logic [15:0] w;
    w = '0;
    foreach (q[i]) w[15-i] = q[i];
    return w;
  endfunction

  // Model: collect the current burst in a queue; a 16-bit burst or a low strobe closes it.
  always @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      mq.delete();
      m_data = '0;
      m_mod  = '0;
      m_val  = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_val = 1'b0;
      if (bus.ser_data_val_i) begin
        mq.push_back(bus.ser_data_i);
        if (mq.size() == 16) begin
          m_data = pack_bits(mq);
          m_mod  = 4'd0;
          m_val  = 1'b1;
          mq.delete();
        end
      end else if (mq.size() > 0) begin
        if (mq.size() >= 3) begin
          m_data = pack_bits(mq);
          m_mod  = 4'(mq.size() % 16);
          m_val  = 1'b1;
        end
        mq.delete();
      end
      m_busy = (mq.size() > 0);
    end
  end

  // ---------------- scoreboard of sent words ----------------
  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
  } exp_t;
  exp_t sbq[$];

  task automatic expect_word(input logic [15:0] data, input int n);
    exp_t e;
    e.d = data & (16'hFFFF << (16 - n));
    e.m = 4'(n % 16);
    sbq.push_back(e);
  endtask

  // Compare process: DUT against model every cycle, and pulses against the scoreboard.
  always @(negedge clk_i) begin
    if (check_en) begin
      chk("val_vs_model",  32'(bus.deser_data_val_o), 32'(m_val));
      chk("busy_vs_model", 32'(bus.busy_o),           32'(m_busy));
      chk("data_vs_model", 32'(bus.deser_data_o),     32'(m_data));
      chk("mod_vs_model",  32'(bus.deser_mod_o),      32'(m_mod));
      if (bus.deser_data_val_o) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_pulse: got data 0x%0h, expected no pulse at %0t",
                   bus.deser_data_o, $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_data", 32'(bus.deser_data_o), 32'(e.d));
          chk("sb_mod",  32'(bus.deser_mod_o),  32'(e.m));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic v, input logic b);
    bus.ser_data_val_i = v;
    bus.ser_data_i     = v ? b : 1'($urandom_range(0, 1));
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] data, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, data[15-i]);
  endtask

  task automatic check_pulse(input string name, input logic [15:0] d, input logic [3:0] m);
    chk({name, "_val"},   32'(bus.deser_data_val_o), 32'd1);
    chk({name, "_data"},  32'(bus.deser_data_o),     32'(d));
    chk({name, "_mod"},   32'(bus.deser_mod_o),      32'(m));
    chk({name, "_model"}, 32'(m_data),               32'(d));
  endtask

  initial begin
    bus.ser_data_val_i = 1'b0;
    bus.ser_data_i     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    srst_i   = 1'b0;
    check_en = 1'b1;

    // Reset then idle.
    repeat (20) tick(1'b0, 1'b0);
    chk("idle_data", 32'(bus.deser_data_o),     32'h0);
    chk("idle_mod",  32'(bus.deser_mod_o),      32'h0);
    chk("idle_val",  32'(bus.deser_data_val_o), 32'h0);
    chk("idle_busy", 32'(bus.busy_o),           32'h0);

    // Full 16-bit frame with busy timing.
    chk("full_busy_before", 32'(bus.busy_o), 32'h0);
    expect_word(16'hA5C3, 16);
    tick(1'b1, 1'b1);
    chk("full_busy_after_bit1", 32'(bus.busy_o), 32'h1);
    for (int i = 1; i < 16; i++) tick(1'b1, 1'(16'hA5C3 >> (15 - i)));
    check_pulse("full", 16'hA5C3, 4'd0);
    chk("full_busy_end", 32'(bus.busy_o), 32'h0);
    tick(1'b0, 1'b0);
    chk("full_pulse_width", 32'(bus.deser_data_val_o), 32'h0);
    tick(1'b0, 1'b0);

    // Back-to-back frames: pulses land exactly 16 cycles apart.
    expect_word(16'h1234, 16);
    expect_word(16'hFEDC, 16);
    send_bits(16'h1234, 16);
    check_pulse("b2b_first", 16'h1234, 4'd0);
    send_bits(16'hFEDC, 16);
    check_pulse("b2b_second", 16'hFEDC, 4'd0);
    repeat (2) tick(1'b0, 1'b0);

    // Short frames.
    expect_word(16'hE000, 3);
    send_bits(16'hE000, 3);
    tick(1'b0, 1'b0);
    check_pulse("short3", 16'hE000, 4'd3);
    tick(1'b0, 1'b0);
    expect_word(16'hB000, 5);
    send_bits(16'hB000, 5);
    tick(1'b0, 1'b0);
    check_pulse("short5", 16'hB000, 4'd5);
    tick(1'b0, 1'b0);

    // Discarded 2-bit burst keeps the previous word.
    send_bits(16'hC000, 2);
    chk("discard_busy_during", 32'(bus.busy_o), 32'h1);
    tick(1'b0, 1'b0);
    chk("discard_val",  32'(bus.deser_data_val_o), 32'h0);
    chk("discard_data", 32'(bus.deser_data_o),     32'hB000);
    chk("discard_mod",  32'(bus.deser_mod_o),      32'h5);
    chk("discard_busy", 32'(bus.busy_o),           32'h0);
    repeat (3) tick(1'b0, 1'b0);

    // Randomized serializator-style traffic.
    for (int f = 0; f < 80; f++) begin
      int r, n, gap;
      logic [15:0] d;
      r   = int'($urandom_range(0, 13));
      n   = (r == 0) ? 16 : r + 2;
      d   = 16'($urandom());
      gap = (n == 16) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      expect_word(d, n);
      send_bits(d, n);
      repeat (gap) tick(1'b0, 1'b0);

      // Mid-run, drop a frame by resetting on its seventh bit.
      if (f == 40) begin
        tick(1'b0, 1'b0);
        d = 16'($urandom());
        send_bits(d, 6);
        bus.ser_data_val_i = 1'b1;
        bus.ser_data_i     = d[9];
        #3;
        srst_i             = 1'b1;
        bus.ser_data_val_i = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy_o),           32'h0);
        chk("rst_mid_val",  32'(bus.deser_data_val_o), 32'h0);
        chk("rst_mid_data", 32'(bus.deser_data_o),     32'h0);
        chk("rst_mid_mod",  32'(bus.deser_mod_o),      32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        repeat (4) tick(1'b0, 1'b0);
        chk("rst_after_data", 32'(bus.deser_data_o), 32'h0);
        chk("rst_after_busy", 32'(bus.busy_o),       32'h0);
      end
    end

    repeat (5) tick(1'b0, 1'b0);
    chk("sb_all_received", 32'(sbq.size()), 32'd0);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
